// File: rtl/vram_pkg.sv
// rtl/vram_pkg.sv - frame-buffer geometry, slot encoding and word-address helper
package vram_pkg;
  localparam int FB_W       = 160;
  localparam int FB_H       = 120;
  localparam int SCALE_LOG2 = 2;
  localparam int ADDR_W     = 15;
  localparam int H_ACTIVE   = 640;
  localparam int V_ACTIVE   = 480;
  localparam int FB_WORDS   = FB_W * FB_H;

  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_SCAN_RUN,
    SLOT_SCAN_LINE,
    SLOT_WRITE
  } slot_e;

  // row*160 as two shifts, so no multiplier sits on the RAM address path
  function automatic logic [ADDR_W-1:0] fb_word_addr(input logic [7:0] row, input logic [7:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(row);
    return (r << 7) + (r << 5) + ADDR_W'(col);
  endfunction
endpackage

// File: rtl/vram_rr_arb2.sv
// rtl/vram_rr_arb2.sv - two-way round-robin grant; pointer moves past the winner on each grant
module vram_rr_arb2 (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output logic       gnt_idx
);
  logic rr_ptr_q, rr_ptr_d;
  logic fire;

  always_comb begin
    gnt_idx  = req[rr_ptr_q] ? rr_ptr_q : ~rr_ptr_q;
    fire     = en && (req != 2'b00);
    gnt      = fire ? (gnt_idx ? 2'b10 : 2'b01) : 2'b00;
    rr_ptr_d = fire ? ~gnt_idx : rr_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) rr_ptr_q <= 1'b0;
    else          rr_ptr_q <= rr_ptr_d;
  end
endmodule

// File: rtl/vram_scan_arbiter.sv
// rtl/vram_scan_arbiter.sv - scanout-priority frame-buffer arbiter with two round-robin writers
// Optional FB_DOUBLE_BUF_EN adds a bank bit to fb_addr plus swap_req/swap_done.
module vram_scan_arbiter
  import vram_pkg::*;
(
  input  logic              pixel_clk,
  input  logic              reset_n,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              display_enable,
  input  logic              frame_sync,
  output logic [7:0]        color_out,
  input  logic [1:0]        wr_req,
  input  logic [ADDR_W-1:0] wr_addr0,
  input  logic [ADDR_W-1:0] wr_addr1,
  input  logic [7:0]        wr_data0,
  input  logic [7:0]        wr_data1,
  output logic [1:0]        wr_gnt,
`ifdef FB_DOUBLE_BUF_EN
  input  logic              swap_req,
  output logic              swap_done,
  output logic [ADDR_W:0]   fb_addr,
`else
  output logic [ADDR_W-1:0] fb_addr,
`endif
  output logic              fb_we,
  output logic [7:0]        fb_wdata,
  input  logic [7:0]        fb_rdata
);
  slot_e             slot;
  logic              prev_de_q, scan_pend_q;
  logic [7:0]        next_pix_q, cur_pix_q;
  logic [7:0]        blk_x, scan_row, scan_col;
  logic              scan_run, scan_line;
  logic [1:0]        arb_gnt;
  logic              arb_idx;
  logic [ADDR_W-1:0] w_addr, addr_w;
  logic [7:0]        w_data;

  assign blk_x     = 8'(pixel_x >> SCALE_LOG2);
  assign scan_run  = display_enable && (pixel_x[1:0] == 2'b01) && (blk_x != 8'(FB_W - 1));
  assign scan_line = prev_de_q && !display_enable;

  always_comb begin
    if (scan_run)                          slot = SLOT_SCAN_RUN;
    else if (scan_line)                    slot = SLOT_SCAN_LINE;
    else if (reset_n && (wr_req != 2'b00)) slot = SLOT_WRITE;
    else                                   slot = SLOT_IDLE;
  end

  // the line-end read targets the following line (wrapping 479 -> 0) so it is ready at x=0
  always_comb begin
    if (scan_run) begin
      scan_row = 8'(pixel_y >> SCALE_LOG2);
      scan_col = blk_x + 8'd1;
    end else begin
      scan_row = (pixel_y == 10'(V_ACTIVE - 1)) ? 8'd0 : 8'((pixel_y + 10'd1) >> SCALE_LOG2);
      scan_col = 8'd0;
    end
  end

  vram_rr_arb2 u_arb (
    .clk     (pixel_clk),
    .reset_n (reset_n),
    .en      (slot == SLOT_WRITE),
    .req     (wr_req),
    .gnt     (arb_gnt),
    .gnt_idx (arb_idx)
  );

  assign w_addr = arb_idx ? wr_addr1 : wr_addr0;
  assign w_data = arb_idx ? wr_data1 : wr_data0;

  // out-of-range writes are still acked so the writer never stalls
  always_comb begin
    wr_gnt   = 2'b00;
    fb_we    = 1'b0;
    fb_wdata = 8'd0;
    addr_w   = '0;
    case (slot)
      SLOT_SCAN_RUN, SLOT_SCAN_LINE: addr_w = fb_word_addr(scan_row, scan_col);
      SLOT_WRITE: begin
        wr_gnt   = arb_gnt;
        fb_we    = (w_addr < ADDR_W'(FB_WORDS));
        fb_wdata = w_data;
        addr_w   = w_addr;
      end
      default: ;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      prev_de_q   <= 1'b0;
      scan_pend_q <= 1'b0;
      next_pix_q  <= 8'd0;
      cur_pix_q   <= 8'd0;
    end else begin
      prev_de_q   <= display_enable;
      scan_pend_q <= (slot == SLOT_SCAN_RUN) || (slot == SLOT_SCAN_LINE);
      if (scan_pend_q) next_pix_q <= fb_rdata;
      if (!display_enable || (pixel_x[1:0] == 2'b11)) cur_pix_q <= next_pix_q;
    end
  end

  assign color_out = cur_pix_q;

`ifdef FB_DOUBLE_BUF_EN
  logic bank_q, swap_pend_q, swap_done_q;

  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      bank_q      <= 1'b0;
      swap_pend_q <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      swap_done_q <= 1'b0;
      if (frame_sync && swap_pend_q) begin
        bank_q      <= ~bank_q;
        swap_pend_q <= 1'b0;
        swap_done_q <= 1'b1;
      end else if (swap_req) begin
        swap_pend_q <= 1'b1;
      end
    end
  end

  assign swap_done = swap_done_q;
  assign fb_addr   = {(slot == SLOT_WRITE) ? ~bank_q : bank_q, addr_w};
`else
  logic unused_frame_sync;
  assign unused_frame_sync = frame_sync;
  assign fb_addr = addr_w;
`endif
endmodule
